// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit framer:
// frame-phase state encoding, preamble/SFD bytes and CRC-32 parameters.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_ERR      = 3'd6,
        ST_IFG      = 3'd7
    } tx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;
    localparam int         FCS_LEN       = 4;

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Ethernet shifts bytes LSB first, so the register runs in reflected form.
    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    function automatic logic [31:0] crc32_step8(input logic [31:0] crc,
                                                input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register. init_i has priority over en_i;
// crc_o is the raw register (final XOR is applied by the consumer).
module crc32_d8
    import eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_step8(crc_q, data_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS,
// underflow abort and inter-frame gap, paced by a byte-slot strobe.
module eth_tx_fcs_ctrl
    import eth_tx_pkg::*;
#(
    parameter int MIN_LEN   = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_ce,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic [15:0] underflow_cnt,
    output tx_state_e  dbg_state_o
);

    localparam int MIN_LEN_CLAMP = (MIN_LEN > 2047) ? 2047 : ((MIN_LEN < 0) ? 0 : MIN_LEN);
    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN_CLAMP);
    localparam logic [15:0] IFG_LAST  = (IFG_BYTES > 0) ? 16'(IFG_BYTES - 1) : 16'd0;
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] FCS_LAST  = 16'(FCS_LEN - 1);

    tx_state_e   state_q, state_d;
    logic [15:0] slot_cnt_q, slot_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic [15:0] ufl_q, ufl_d;

    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_val;
    logic [31:0] fcs_val;
    logic [7:0]  fcs_byte;
    logic [10:0] byte_cnt_inc;
    logic        reached_min;

    // Handshake: a payload byte moves when s_valid && s_ready; s_ready is only
    // ever high on a strobe cycle in DATA, so the source may hold s_valid freely.
    assign s_ready = byte_ce & (state_q == ST_DATA) & s_valid;

    assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign reached_min  = (byte_cnt_inc >= MIN_LEN_W);
    assign fcs_val      = crc_val ^ CRC_XOROUT;

    always_comb begin
        case (slot_cnt_q[1:0])
            2'd0:    fcs_byte = fcs_val[7:0];
            2'd1:    fcs_byte = fcs_val[15:8];
            2'd2:    fcs_byte = fcs_val[23:16];
            default: fcs_byte = fcs_val[31:24];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = tx_en_q;
        tx_er_d    = tx_er_q;
        ufl_d      = ufl_q;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        crc_data   = s_data;
        if (byte_ce) begin
            // Each strobe emits exactly one wire slot; idle unless a state says otherwise.
            tx_data_d = 8'h00;
            tx_en_d   = 1'b0;
            tx_er_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        state_d    = ST_PREAMBLE;
                        slot_cnt_d = 16'd1;
                        tx_data_d  = PREAMBLE_BYTE;
                        tx_en_d    = 1'b1;
                    end
                end
                ST_PREAMBLE: begin
                    tx_data_d  = PREAMBLE_BYTE;
                    tx_en_d    = 1'b1;
                    slot_cnt_d = slot_cnt_q + 16'd1;
                    if (slot_cnt_q == PRE_LAST) begin
                        state_d = ST_SFD;
                    end
                end
                ST_SFD: begin
                    tx_data_d  = SFD_BYTE;
                    tx_en_d    = 1'b1;
                    crc_init   = 1'b1;
                    byte_cnt_d = 11'd0;
                    slot_cnt_d = 16'd0;
                    state_d    = ST_DATA;
                end
                ST_DATA: begin
                    tx_en_d = 1'b1;
                    if (s_valid) begin
                        tx_data_d  = s_data;
                        crc_en     = 1'b1;
                        byte_cnt_d = byte_cnt_inc;
                        if (s_last) begin
                            state_d = reached_min ? ST_FCS : ST_PAD;
                        end
                    end else begin
                        // Source starved mid-frame: poison this slot and abandon the frame.
                        tx_er_d = 1'b1;
                        ufl_d   = (ufl_q == 16'hFFFF) ? ufl_q : ufl_q + 16'd1;
                        state_d = ST_ERR;
                    end
                end
                ST_PAD: begin
                    tx_en_d    = 1'b1;
                    crc_en     = 1'b1;
                    crc_data   = 8'h00;
                    byte_cnt_d = byte_cnt_inc;
                    if (reached_min) begin
                        state_d = ST_FCS;
                    end
                end
                ST_FCS: begin
                    tx_data_d  = fcs_byte;
                    tx_en_d    = 1'b1;
                    slot_cnt_d = slot_cnt_q + 16'd1;
                    if (slot_cnt_q == FCS_LAST) begin
                        slot_cnt_d = 16'd0;
                        state_d    = (IFG_BYTES > 0) ? ST_IFG : ST_IDLE;
                    end
                end
                ST_ERR: begin
                    // This idle slot is the first gap slot after the error byte.
                    slot_cnt_d = 16'd1;
                    state_d    = (IFG_BYTES > 1) ? ST_IFG : ST_IDLE;
                end
                ST_IFG: begin
                    slot_cnt_d = slot_cnt_q + 16'd1;
                    if (slot_cnt_q >= IFG_LAST) begin
                        slot_cnt_d = 16'd0;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            ufl_q      <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            ufl_q      <= ufl_d;
        end
    end

    crc32_d8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (crc_data),
        .crc_o  (crc_val)
    );

    assign tx_data       = tx_data_q;
    assign tx_en         = tx_en_q;
    assign tx_er         = tx_er_q;
    assign busy          = (state_q != ST_IDLE);
    assign underflow_cnt = ufl_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Directed bench for eth_tx_fcs_ctrl: a no-pad instance for the CRC check
// vector and a default instance for padding, pacing, underflow and reset.
module tb_eth_tx_fcs_ctrl;
    import eth_tx_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       byte_ce = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;

    logic       s_ready_0, tx_en_0, tx_er_0, busy_0;
    logic [7:0] tx_data_0;
    logic [15:0] ufl_0;
    tx_state_e  st_0;
    logic       s_ready_1, tx_en_1, tx_er_1, busy_1;
    logic [7:0] tx_data_1;
    logic [15:0] ufl_1;
    tx_state_e  st_1;

    eth_tx_fcs_ctrl #(.MIN_LEN(0), .IFG_BYTES(12)) dut_nopad (
        .clk(clk), .rst(rst), .byte_ce(byte_ce), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready_0), .tx_data(tx_data_0), .tx_en(tx_en_0),
        .tx_er(tx_er_0), .busy(busy_0), .underflow_cnt(ufl_0), .dbg_state_o(st_0)
    );

    eth_tx_fcs_ctrl #(.MIN_LEN(60), .IFG_BYTES(12)) dut (
        .clk(clk), .rst(rst), .byte_ce(byte_ce), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready_1), .tx_data(tx_data_1), .tx_en(tx_en_1),
        .tx_er(tx_er_1), .busy(busy_1), .underflow_cnt(ufl_1), .dbg_state_o(st_1)
    );

    logic mon_sel = 1'b0;
    logic m_en, m_er, m_ready, m_busy;
    logic [7:0] m_data;
    assign m_en    = mon_sel ? tx_en_1   : tx_en_0;
    assign m_er    = mon_sel ? tx_er_1   : tx_er_0;
    assign m_data  = mon_sel ? tx_data_1 : tx_data_0;
    assign m_ready = mon_sel ? s_ready_1 : s_ready_0;
    assign m_busy  = mon_sel ? busy_1    : busy_0;

    // Byte-slot strobe: high every ce_div-th cycle, changed on the falling edge.
    int ce_div = 1;
    int ce_phase = 0;
    initial begin
        forever begin
            @(negedge clk);
            ce_phase = (ce_phase + 1) % ce_div;
            byte_ce  = (ce_phase == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    logic [7:0] pay[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic ce_seen = 1'b0;
    always @(posedge clk) ce_seen <= byte_ce;

    int en_run = 0, idle_run = 0, last_burst = 0, last_gap = 0;
    logic [9:0] prev_out = '0;
    logic [8:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            en_run   = 0;
            idle_run = 0;
        end else if (ce_seen) begin
            if (m_en) begin
                if (en_run == 0) last_gap = idle_run;
                en_run++;
                idle_run = 0;
                chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    chk("tx_byte", 32'({m_er, m_data}), 32'(exp_v));
                end
            end else begin
                if (en_run > 0) last_burst = en_run;
                en_run = 0;
                idle_run++;
                chk("idle_slot", 32'({m_er, m_data}), 32'd0);
            end
        end else begin
            chk("hold_between_strobes", 32'({m_en, m_er, m_data}), 32'(prev_out));
        end
        prev_out = {m_en, m_er, m_data};
    end

    always @(negedge clk) begin
        #3;
        if (m_ready) chk("ready_only_on_strobe", 32'(byte_ce), 32'd1);
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic last);
        int  n = 0;
        bit  done = 0;
        s_data = d; s_valid = 1'b1; s_last = last;
        while (!done && n < 500) begin
            @(negedge clk); #2; n++;
            if (m_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        chk("send_byte_accepted", 32'(done), 32'd1);
    endtask

    task automatic drive_pay(input int n, input bit mark_last);
        for (int i = 0; i < n; i++) send_byte(pay[i], mark_last && (i == n - 1));
    endtask

    task automatic push_pre();
        repeat (7) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
    endtask

    task automatic push_frame_exp(input int min_len);
        logic [31:0] c = 32'hFFFFFFFF;
        push_pre();
        foreach (pay[i]) begin
            exp_q.push_back({1'b0, pay[i]});
            c = crc_upd(c, pay[i]);
        end
        for (int i = pay.size(); i < min_len; i++) begin
            exp_q.push_back(9'h000);
            c = crc_upd(c, 8'h00);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_frame_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || m_busy) && n < 3000) begin
            @(negedge clk); #3; n++;
        end
        chk({tag, "_done"}, 32'(n < 3000), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_tx_en", 32'({tx_en_0, tx_en_1}), 32'd0);
        chk("rst_tx_er", 32'({tx_er_0, tx_er_1}), 32'd0);
        chk("rst_tx_data", 32'({tx_data_0, tx_data_1}), 32'd0);
        chk("rst_s_ready", 32'({s_ready_0, s_ready_1}), 32'd0);
        chk("rst_busy", 32'({busy_0, busy_1}), 32'd0);
        chk("rst_ufl", 32'({ufl_0, ufl_1}), 32'd0);
        chk("rst_state", 32'(st_1), 32'd0);
        s_valid = 1'b0;
        @(negedge clk); #2; rst = 1'b0;

        // Check vector "123456789" with padding disabled.
        mon_sel = 1'b0;
        pay.delete();
        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        push_pre();
        foreach (pay[i]) exp_q.push_back({1'b0, pay[i]});
        exp_q.push_back(9'h026); exp_q.push_back(9'h039);
        exp_q.push_back(9'h0F4); exp_q.push_back(9'h0CB);
        drive_pay(9, 1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_frame_done("t1");
        chk("t1_burst_len", 32'(last_burst), 32'd21);
        chk("t1_ifg_slots", 32'(idle_run), 32'd12);

        @(negedge clk); #2; rst = 1'b1;
        @(negedge clk); #2; exp_q.delete(); mon_sel = 1'b1; rst = 1'b0;

        // Single zero byte padded to MIN_LEN; also first-byte latency.
        pay.delete(); pay.push_back(8'h00);
        push_frame_exp(60);
        @(negedge clk); #2;
        s_data = 8'h00; s_valid = 1'b1; s_last = 1'b1;
        @(posedge clk); #1;
        chk("t2_latency_en", 32'({tx_en_1, tx_data_1}), 32'h155);
        chk("t2_latency_busy", 32'(busy_1), 32'd1);
        drive_pay(1, 1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_frame_done("t2");
        chk("t2_burst_len", 32'(last_burst), 32'd72);

        // Strobe every second cycle, 64-byte frame.
        ce_div = 2;
        fill_random(64);
        push_frame_exp(60);
        drive_pay(64, 1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_frame_done("t3");
        chk("t3_burst_len", 32'(last_burst), 32'd76);
        ce_div = 1;
        repeat (2) @(negedge clk);

        // Underflow after 10 bytes, followed at once by a normal frame.
        fill_random(10);
        push_pre();
        foreach (pay[i]) exp_q.push_back({1'b0, pay[i]});
        exp_q.push_back(9'h100);
        drive_pay(10, 0);
        s_valid = 1'b0;
        n = 0;
        while (ufl_1 != 16'd1 && n < 50) begin @(negedge clk); #3; n++; end
        chk("t4_ufl_seen", 32'(ufl_1), 32'd1);
        chk("t4_err_burst", 32'(en_run), 32'd19);
        chk("t4_tx_er", 32'(tx_er_1), 32'd1);
        fill_random(64);
        push_frame_exp(60);
        drive_pay(64, 1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_frame_done("t4");
        chk("t4_gap_after_err", 32'(last_gap), 32'd12);
        chk("t4_ufl_final", 32'(ufl_1), 32'd1);
        chk("t4_next_burst", 32'(last_burst), 32'd76);

        // Back-to-back frames with s_valid held high.
        fill_random(60);
        push_frame_exp(60);
        drive_pay(60, 1);
        fill_random(60);
        push_frame_exp(60);
        drive_pay(60, 1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_frame_done("t5");
        chk("t5_gap", 32'(last_gap), 32'd12);
        chk("t5_burst_len", 32'(last_burst), 32'd72);

        // Reset while FCS byte 2 is on the wire.
        fill_random(64);
        push_frame_exp(60);
        drive_pay(64, 1);
        s_valid = 1'b0; s_last = 1'b0;
        n = 0;
        while (en_run != 74 && n < 50) begin @(negedge clk); #3; n++; end
        chk("t6_reached_fcs2", 32'(en_run), 32'd74);
        #2; rst = 1'b1;
        #1;
        chk("t6_tx_en_cut", 32'({tx_en_1, tx_er_1, tx_data_1}), 32'd0);
        chk("t6_busy", 32'(busy_1), 32'd0);
        chk("t6_ufl_cleared", 32'(ufl_1), 32'd0);
        chk("t6_state", 32'(st_1), 32'd0);
        @(negedge clk); #2;
        chk("t6_tx_en_held", 32'(tx_en_1), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        fill_random(20);
        push_frame_exp(60);
        drive_pay(20, 1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_frame_done("t6");
        chk("t6_burst_len", 32'(last_burst), 32'd72);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
